// File: rtl/ceps_delta.sv
// ceps_delta: rings the most recent cepstral frames from the DCT and, per completed
// frame, emits the +/-2 frame regression delta alongside the centre-frame static value.
module ceps_delta #(
  parameter int          NUM_CEPS   = 12,
  parameter int          CEPS_WIDTH = 16,
  parameter logic [15:0] RECIP      = 16'd3277,
  parameter int          NUM_SLOTS  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [$clog2(NUM_CEPS)-1:0]   frame_ptr_i,
  input  logic signed [CEPS_WIDTH-1:0]  ceps_in,
  input  logic                          start_i,
  output logic                          delta_valid_o,
  output logic [$clog2(NUM_CEPS)-1:0]   delta_ptr_o,
  output logic signed [CEPS_WIDTH-1:0]  delta_out,
  output logic signed [CEPS_WIDTH-1:0]  static_out,
  output logic                          delta_done_o,
  output logic                          overrun_o
);
  localparam int PW = $clog2(NUM_CEPS);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int NW = CEPS_WIDTH + 3;
  localparam int RW = $bits(RECIP) + 1;
  localparam int MW = NW + RW;
  localparam logic [PW-1:0] LAST_K = PW'(NUM_CEPS - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
  localparam logic [2:0] WARM_FRAMES = 3'd5;
  localparam logic signed [MW-1:0] HALF = MW'(16384);
  localparam logic signed [MW-1:0] MAXV = MW'(2**(CEPS_WIDTH-1) - 1);
  localparam logic signed [MW-1:0] MINV = -MAXV - MW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [SW-1:0] wr_slot;
  logic [SW-1:0] newest;
  logic [2:0]    frames_seen;
  logic [PW-1:0] k;

  logic signed [CEPS_WIDTH-1:0] ring_mem [NUM_SLOTS][NUM_CEPS];

  logic signed [NW-1:0]         c_tp2, c_tp1, c_tm1, c_tm2;
  logic signed [CEPS_WIDTH-1:0] c_t;
  logic signed [NW-1:0]         num_k;

  logic                         s1_valid;
  logic [PW-1:0]                s1_ptr;
  logic signed [NW-1:0]         s1_num;
  logic signed [CEPS_WIDTH-1:0] s1_static;

  logic signed [MW-1:0]         prod;
  logic signed [MW-1:0]         rounded;
  logic signed [CEPS_WIDTH-1:0] delta_sat;

  function automatic logic [SW-1:0] slot_back(input logic [SW-1:0] s, input int back);
    int t;
    t = int'(s) - back;
    if (t < 0) t = t + NUM_SLOTS;
    return SW'(t);
  endfunction

  // Buffer is never cleared; warm-up counting keeps stale slots out of the window.
  always_ff @(posedge clk) begin
    if (in_valid && frame_ptr_i <= LAST_K)
      ring_mem[wr_slot][frame_ptr_i] <= ceps_in;
  end

  always_comb begin
    c_tp2 = NW'(ring_mem[slot_back(newest, 0)][k]);
    c_tp1 = NW'(ring_mem[slot_back(newest, 1)][k]);
    c_t   = ring_mem[slot_back(newest, 2)][k];
    c_tm1 = NW'(ring_mem[slot_back(newest, 3)][k]);
    c_tm2 = NW'(ring_mem[slot_back(newest, 4)][k]);
    num_k = ((c_tp2 - c_tm2) <<< 1) + (c_tp1 - c_tm1);
  end

  always_comb begin
    prod    = MW'(s1_num) * MW'($signed({1'b0, RECIP}));
    rounded = (prod + HALF) >>> 15;
    if (rounded > MAXV)      delta_sat = CEPS_WIDTH'(MAXV);
    else if (rounded < MINV) delta_sat = CEPS_WIDTH'(MINV);
    else                     delta_sat = CEPS_WIDTH'(rounded);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_slot      <= '0;
      newest       <= '0;
      frames_seen  <= '0;
      k            <= '0;
      delta_done_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      delta_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            newest  <= wr_slot;
            wr_slot <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + 1'b1;
            if (frames_seen != WARM_FRAMES) frames_seen <= frames_seen + 1'b1;
            if (frames_seen >= WARM_FRAMES - 3'd1) begin
              state <= RUN;
              k     <= '0;
            end
          end
        end
        RUN: begin
          if (k == LAST_K) begin
            state <= DRAIN;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: state <= DONE;
        DONE: begin
          state        <= IDLE;
          delta_done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // A frame-done strobe while busy is dropped; the in-flight frame continues untouched.
      if (start_i && state != IDLE) overrun_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_ptr        <= '0;
      s1_num        <= '0;
      s1_static     <= '0;
      delta_valid_o <= 1'b0;
      delta_ptr_o   <= '0;
      delta_out     <= '0;
      static_out    <= '0;
    end else begin
      s1_valid <= (state == RUN);
      if (state == RUN) begin
        s1_ptr    <= k;
        s1_num    <= num_k;
        s1_static <= c_t;
      end
      delta_valid_o <= s1_valid;
      if (s1_valid) begin
        delta_ptr_o <= s1_ptr;
        delta_out   <= delta_sat;
        static_out  <= s1_static;
      end
    end
  end
endmodule

// File: tb/tb_ceps_delta.sv
// tb_ceps_delta: scoreboard bench driving two ceps_delta instances (nominal and
// full-scale reciprocal) with identical frames and checking every output against a ring model.
module tb_ceps_delta;
  localparam int NC = 12;
  localparam int NS = 6;

  typedef logic signed [15:0] frame_t [NC];
  typedef struct { int ptr; int delta; int stat; } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [3:0]        frame_ptr_i;
  logic signed [15:0] ceps_in;
  logic              start_i;

  logic              dv [2];
  logic [3:0]        dp [2];
  logic signed [15:0] dd [2];
  logic signed [15:0] ds [2];
  logic              done [2];
  logic              ovr [2];

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;

  exp_t   q0[$];
  exp_t   q1[$];
  frame_t mring [NS];
  int m_wr, m_newest, m_seen;
  int vcount [2];
  int first_v [2];
  int last_v [2];
  int done_c [2];
  int done_count [2];

  ceps_delta dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_ptr_i(frame_ptr_i),
    .ceps_in(ceps_in), .start_i(start_i), .delta_valid_o(dv[0]), .delta_ptr_o(dp[0]),
    .delta_out(dd[0]), .static_out(ds[0]), .delta_done_o(done[0]), .overrun_o(ovr[0])
  );

  ceps_delta #(.RECIP(16'd32767)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_ptr_i(frame_ptr_i),
    .ceps_in(ceps_in), .start_i(start_i), .delta_valid_o(dv[1]), .delta_ptr_o(dp[1]),
    .delta_out(dd[1]), .static_out(ds[1]), .delta_done_o(done[1]), .overrun_o(ovr[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int modelDelta(input int num, input longint recip);
    longint p;
    p = (longint'(num) * recip + 64'sd16384) >>> 15;
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return int'(p);
  endfunction

  task automatic commitModel(output bit produced);
    int tp2, tp1, tc, tm1, tm2, num;
    m_newest = m_wr;
    m_wr = (m_wr + 1) % NS;
    if (m_seen < 5) m_seen++;
    produced = (m_seen == 5);
    if (produced) begin
      for (int k = 0; k < NC; k++) begin
        tp2 = mring[m_newest][k];
        tp1 = mring[(m_newest + NS - 1) % NS][k];
        tc  = mring[(m_newest + NS - 2) % NS][k];
        tm1 = mring[(m_newest + NS - 3) % NS][k];
        tm2 = mring[(m_newest + NS - 4) % NS][k];
        num = 2 * (tp2 - tm2) + (tp1 - tm1);
        q0.push_back('{k, modelDelta(num, 3277), tc});
        q1.push_back('{k, modelDelta(num, 32767), tc});
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      if (done[d]) begin
        done_count[d]++;
        done_c[d] = cyc;
      end
      if (dv[d]) begin
        if (vcount[d] == 0) first_v[d] = cyc;
        vcount[d]++;
        last_v[d] = cyc;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          checkOutput($sformatf("d%0d_unexpected_valid", d), 1, 0);
        end else begin
          checkOutput($sformatf("d%0d_ptr", d), int'(dp[d]), e.ptr);
          checkOutput($sformatf("d%0d_delta_k%0d", d, e.ptr), int'(dd[d]), e.delta);
          checkOutput($sformatf("d%0d_static_k%0d", d, e.ptr), int'(ds[d]), e.stat);
        end
      end
    end
  end

  task automatic applyStimulus(input frame_t v, input bit merge_last, input bit inject_ovr,
                               input bit abort_run, input bit check_timing);
    int e0;
    bit produced;
    @(negedge clk);
    in_valid = 1'b1; frame_ptr_i = 4'd13; ceps_in = 16'sh7abc;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      in_valid = 1'b1; frame_ptr_i = 4'(k); ceps_in = v[k];
      mring[m_wr][k] = v[k];
      if (merge_last && k == NC - 1) start_i = 1'b1;
    end
    if (!merge_last) begin
      @(negedge clk);
      in_valid = 1'b0; start_i = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; start_i = 1'b0;
    e0 = cyc;
    for (int d = 0; d < 2; d++) begin
      vcount[d] = 0; done_count[d] = 0; first_v[d] = -1; last_v[d] = -1; done_c[d] = -1;
    end
    commitModel(produced);

    if (inject_ovr) begin
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_ovr_before", d), int'(ovr[d]), 0);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_ovr_after", d), int'(ovr[d]), 1);
    end

    if (abort_run) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #1;
        if (vcount[0] >= 4) break;
      end
      checkOutput("abort_reach_4th_valid", vcount[0], 4);
      rst = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("d%0d_abort_valid", d), int'(dv[d]), 0);
        checkOutput($sformatf("d%0d_abort_ptr", d), int'(dp[d]), 0);
        checkOutput($sformatf("d%0d_abort_delta", d), int'(dd[d]), 0);
        checkOutput($sformatf("d%0d_abort_static", d), int'(ds[d]), 0);
        checkOutput($sformatf("d%0d_abort_done", d), int'(done[d]), 0);
        checkOutput($sformatf("d%0d_abort_ovr", d), int'(ovr[d]), 0);
      end
      rst = 1'b0;
      q0.delete(); q1.delete();
      m_wr = 0; m_newest = 0; m_seen = 0;
      repeat (20) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("d%0d_abort_no_done", d), done_count[d], 0);
        checkOutput($sformatf("d%0d_abort_valid_count", d), vcount[d], 4);
      end
    end else if (produced) begin
      for (int i = 0; i < 40 && !(done_count[0] > 0 && done_count[1] > 0); i++) @(negedge clk);
      if (!(done_count[0] > 0 && done_count[1] > 0)) checkOutput("done_timeout", 0, 1);
      repeat (2) @(negedge clk);
      if (check_timing) begin
        for (int d = 0; d < 2; d++) begin
          checkOutput($sformatf("d%0d_valid_count", d), vcount[d], NC);
          checkOutput($sformatf("d%0d_first_valid_lat", d), first_v[d] - e0, 2);
          checkOutput($sformatf("d%0d_last_valid_lat", d), last_v[d] - e0, NC + 1);
          checkOutput($sformatf("d%0d_done_lat", d), done_c[d] - e0, NC + 2);
          checkOutput($sformatf("d%0d_done_pulses", d), done_count[d], 1);
        end
      end
    end else begin
      repeat (4) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("d%0d_warmup_quiet", d), vcount[d], 0);
        checkOutput($sformatf("d%0d_warmup_no_done", d), done_count[d], 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_t fr;
    rst = 1'b1; in_valid = 1'b0; frame_ptr_i = '0; ceps_in = '0; start_i = 1'b0;
    m_wr = 0; m_newest = 0; m_seen = 0;
    for (int d = 0; d < 2; d++) begin
      vcount[d] = 0; first_v[d] = -1; last_v[d] = -1; done_c[d] = -1; done_count[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d_rst_valid", d), int'(dv[d]), 0);
      checkOutput($sformatf("d%0d_rst_ptr", d), int'(dp[d]), 0);
      checkOutput($sformatf("d%0d_rst_delta", d), int'(dd[d]), 0);
      checkOutput($sformatf("d%0d_rst_static", d), int'(ds[d]), 0);
      checkOutput($sformatf("d%0d_rst_done", d), int'(done[d]), 0);
      checkOutput($sformatf("d%0d_rst_ovr", d), int'(ovr[d]), 0);
    end
    rst = 1'b0;

    $display("[TB] linear ramp with warm-up");
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < NC; k++) fr[k] = 16'(100 * f);
      applyStimulus(fr, 1'b0, 1'b0, 1'b0, f == 4);
    end

    $display("[TB] constant frames");
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < NC; k++) fr[k] = -16'sd500;
      applyStimulus(fr, f[0], 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] saturation windows");
    for (int s = 0; s < 2; s++) begin
      for (int f = 0; f < 5; f++) begin
        for (int k = 0; k < NC; k++) begin
          if (f == 2)                 fr[k] = 16'sd0;
          else if ((f < 2) == (s == 0)) fr[k] = -16'sd32768;
          else                        fr[k] = 16'sd32767;
        end
        applyStimulus(fr, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NC; k++) fr[k] = 16'($urandom);
      applyStimulus(fr, f == 1, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] overrun");
    for (int k = 0; k < NC; k++) fr[k] = 16'($urandom_range(0, 4000)) - 16'sd2000;
    applyStimulus(fr, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NC; k++) fr[k] = 16'($urandom);
    applyStimulus(fr, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset during run");
    for (int k = 0; k < NC; k++) fr[k] = 16'($urandom);
    applyStimulus(fr, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < NC; k++) fr[k] = 16'($urandom);
      applyStimulus(fr, 1'b0, 1'b0, 1'b0, f == 4);
    end

    checkOutput("q0_leftover", q0.size(), 0);
    checkOutput("q1_leftover", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
